// File: rtl/uart_pkg.sv
// Shared UART definitions: bus widths and the state encodings used by the
// transmit fetch engine.
package uart_pkg;

  localparam int UART_ADDR_W = 16;
  localparam int UART_DATA_W = 32;
  localparam int UART_CHAR_W = 8;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_t;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } send_state_t;

endpackage

// File: rtl/uart_tx_char_buffer.sv
// One-entry character holding register between the memory fetch and the
// transmitter; a fill in the same cycle as a drain leaves the entry valid.
module uart_tx_char_buffer
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fill,
  input  logic [UART_CHAR_W-1:0] fill_char,
  input  logic                   drain,
  output logic                   valid,
  output logic [UART_CHAR_W-1:0] buf_char
);

  logic                   valid_q, valid_d;
  logic [UART_CHAR_W-1:0] char_q,  char_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    char_d  = char_q;
    if (drain) valid_d = 1'b0;
    if (fill) begin
      valid_d = 1'b1;
      char_d  = fill_char;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      char_q  <= '0;
    end else begin
      valid_q <= valid_d;
      char_q  <= char_d;
    end
  end

  assign valid    = valid_q;
  assign buf_char = char_q;

endmodule

// File: rtl/uart_tx_fetch_engine.sv
// Transmit-side DMA engine: reads one character per word from [start, stop)
// over Avalon-MM and hands each to the transmitter, prefetching one ahead.
module uart_tx_fetch_engine
  import uart_pkg::*;
#(
  parameter int ADDR_STEP = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   control_trans_start,
  input  logic [UART_ADDR_W-1:0] control_trans_start_addr,
  input  logic [UART_ADDR_W-1:0] control_trans_stop_addr,
  output logic                   control_trans_work,
  output logic [UART_CHAR_W-1:0] trans_char,
  output logic                   trans_start,
  input  logic                   trans_finish,
  output logic                   avm_m1_read,
  output logic                   avm_m1_write,
  output logic [UART_ADDR_W-1:0] avm_m1_address,
  output logic [UART_DATA_W-1:0] avm_m1_writedata,
  input  logic                   avm_m1_waitrequest,
  input  logic                   avm_m1_readdatavalid,
  input  logic [UART_DATA_W-1:0] avm_m1_readdata
);

  fetch_state_t           fetch_state_q, fetch_state_d;
  send_state_t            send_state_q,  send_state_d;
  logic [UART_ADDR_W-1:0] fetch_addr_q,  fetch_addr_d;
  logic [UART_ADDR_W-1:0] stop_q,        stop_d;
  logic [UART_CHAR_W-1:0] trans_char_q,  trans_char_d;
  logic                   work_q,        work_d;

  logic                   start_accept;
  logic                   buf_fill;
  logic                   buf_valid;
  logic [UART_CHAR_W-1:0] buf_char;
  logic                   unused_readdata;

  assign start_accept    = control_trans_start && !work_q;
  assign unused_readdata = ^avm_m1_readdata[UART_DATA_W-1:UART_CHAR_W];

  // Fetch side. The read is launched directly from the start so it appears the
  // cycle after acceptance rather than one cycle later via the idle check.
  always_comb begin
    fetch_state_d = fetch_state_q;
    fetch_addr_d  = fetch_addr_q;
    stop_d        = stop_q;
    buf_fill      = 1'b0;
    if (start_accept) begin
      fetch_addr_d = control_trans_start_addr;
      stop_d       = control_trans_stop_addr;
    end
    unique case (fetch_state_q)
      F_IDLE: begin
        if (start_accept) begin
          if (control_trans_start_addr != control_trans_stop_addr) fetch_state_d = F_REQ;
        end else if (work_q && !buf_valid && fetch_addr_q != stop_q) begin
          fetch_state_d = F_REQ;
        end
      end
      F_REQ: begin
        if (!avm_m1_waitrequest) begin
          fetch_state_d = F_WAIT;
          fetch_addr_d  = fetch_addr_q + UART_ADDR_W'(ADDR_STEP);
        end
      end
      F_WAIT: begin
        if (avm_m1_readdatavalid) begin
          buf_fill      = 1'b1;
          fetch_state_d = F_IDLE;
        end
      end
      default: fetch_state_d = F_IDLE;
    endcase
  end

  // Send side; trans_char shows the buffer during the load pulse and then holds.
  always_comb begin
    send_state_d = send_state_q;
    trans_start  = 1'b0;
    trans_char_d = trans_char_q;
    unique case (send_state_q)
      S_IDLE: begin
        if (buf_valid) begin
          trans_start  = 1'b1;
          trans_char_d = buf_char;
          send_state_d = S_WAIT;
        end
      end
      S_WAIT: if (trans_finish) send_state_d = S_IDLE;
      default: send_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    work_d = work_q;
    if (start_accept) begin
      work_d = 1'b1;
    end else if (work_q && fetch_addr_q == stop_q && fetch_state_q == F_IDLE &&
                 !buf_valid && send_state_q == S_IDLE) begin
      work_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_state_q <= F_IDLE;
      send_state_q  <= S_IDLE;
      fetch_addr_q  <= '0;
      stop_q        <= '0;
      trans_char_q  <= '0;
      work_q        <= 1'b0;
    end else begin
      fetch_state_q <= fetch_state_d;
      send_state_q  <= send_state_d;
      fetch_addr_q  <= fetch_addr_d;
      stop_q        <= stop_d;
      trans_char_q  <= trans_char_d;
      work_q        <= work_d;
    end
  end

  uart_tx_char_buffer u_char_buffer (
    .clk       (clk),
    .rst       (rst),
    .fill      (buf_fill),
    .fill_char (avm_m1_readdata[UART_CHAR_W-1:0]),
    .drain     (trans_start),
    .valid     (buf_valid),
    .buf_char  (buf_char)
  );

  assign control_trans_work = work_q;
  assign trans_char         = trans_char_d;
  assign avm_m1_read        = (fetch_state_q == F_REQ);
  assign avm_m1_write       = 1'b0;
  assign avm_m1_address     = fetch_addr_q;
  assign avm_m1_writedata   = '0;

endmodule

// File: tb/tb_uart_tx_fetch_engine.sv
// Bench for uart_tx_fetch_engine: Avalon slave and transmitter models feed
// address/character scoreboards; each scenario task checks its own outcome.
module tb_uart_tx_fetch_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        control_trans_start;
  logic [15:0] control_trans_start_addr;
  logic [15:0] control_trans_stop_addr;
  logic        control_trans_work;
  logic [7:0]  trans_char;
  logic        trans_start;
  logic        trans_finish;
  logic        avm_m1_read;
  logic        avm_m1_write;
  logic [15:0] avm_m1_address;
  logic [31:0] avm_m1_writedata;
  logic        avm_m1_waitrequest;
  logic        avm_m1_readdatavalid;
  logic [31:0] avm_m1_readdata;

  uart_tx_fetch_engine #(.ADDR_STEP(1)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .control_trans_start      (control_trans_start),
    .control_trans_start_addr (control_trans_start_addr),
    .control_trans_stop_addr  (control_trans_stop_addr),
    .control_trans_work       (control_trans_work),
    .trans_char               (trans_char),
    .trans_start              (trans_start),
    .trans_finish             (trans_finish),
    .avm_m1_read              (avm_m1_read),
    .avm_m1_write             (avm_m1_write),
    .avm_m1_address           (avm_m1_address),
    .avm_m1_writedata         (avm_m1_writedata),
    .avm_m1_waitrequest       (avm_m1_waitrequest),
    .avm_m1_readdatavalid     (avm_m1_readdatavalid),
    .avm_m1_readdata          (avm_m1_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboards: expected values pushed by the scenario, popped on DUT output.
  logic [15:0] exp_addrs[$];
  logic [7:0]  exp_chars[$];

  logic [7:0]  mem [0:65535];

  // Slave model state
  int          stall_left = 0;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [7:0]  pend_data;
  int          read_count = 0;
  int          rdv_count = 0;
  int          rdv_cyc = 0;
  int          reads_while_busy = 0;

  // Transmitter model state
  int          fin_delay = 20;
  int          fin_cnt = 0;
  int          fin_cyc = 0;
  int          ts_count = 0;
  int          first_lat = -1;

  // Work monitor state
  bit          prev_work = 0;
  int          work_fall_cyc = 0;
  int          work_hi_cnt = 0;

  // Avalon slave: fixed read latency, optional stall on the next request(s).
  initial begin
    logic [15:0] e;
    avm_m1_waitrequest   = 1'b0;
    avm_m1_readdatavalid = 1'b0;
    avm_m1_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      avm_m1_readdatavalid = 1'b0;
      if (pend) begin
        if (pend_cnt == 0) begin
          avm_m1_readdatavalid = 1'b1;
          avm_m1_readdata      = {24'hA5C3E1, pend_data};
          pend                 = 0;
          rdv_cyc              = cyc;
          rdv_count++;
        end else begin
          pend_cnt--;
        end
      end
      if (avm_m1_read && stall_left > 0) begin
        avm_m1_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_m1_waitrequest = 1'b0;
      end
      if (avm_m1_read && !avm_m1_waitrequest) begin
        pend      = 1;
        pend_cnt  = 1;
        pend_data = mem[avm_m1_address];
        read_count++;
        if (fin_cnt > 0) reads_while_busy++;
        n_checks++;
        if (exp_addrs.size() == 0) begin
          $display("FAIL read_addr: unexpected read at %h", avm_m1_address);
        end else begin
          e = exp_addrs.pop_front();
          if (avm_m1_address !== e)
            $display("FAIL read_addr: got %h expected %h", avm_m1_address, e);
          else
            n_pass++;
        end
      end
    end
  end

  // Transmitter: accepts trans_start, answers with trans_finish fin_delay cycles later.
  initial begin
    logic [7:0] e;
    trans_finish = 1'b0;
    forever begin
      @(negedge clk);
      trans_finish = 1'b0;
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) begin
          trans_finish = 1'b1;
          fin_cyc      = cyc;
        end
      end
      if (trans_start === 1'b1) begin
        if (ts_count == 0) first_lat = cyc - rdv_cyc;
        ts_count++;
        fin_cnt = fin_delay;
        n_checks++;
        if (exp_chars.size() == 0) begin
          $display("FAIL trans_char: unexpected trans_start with %h", trans_char);
        end else begin
          e = exp_chars.pop_front();
          if (trans_char !== e)
            $display("FAIL trans_char: got %h expected %h", trans_char, e);
          else
            n_pass++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (control_trans_work === 1'b1) work_hi_cnt++;
      if (prev_work && control_trans_work === 1'b0) work_fall_cyc = cyc;
      prev_work = (control_trans_work === 1'b1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [15:0] s, input logic [15:0] e,
                             output logic r1, output logic [15:0] a1);
    @(negedge clk);
    control_trans_start      = 1'b1;
    control_trans_start_addr = s;
    control_trans_stop_addr  = e;
    @(negedge clk);
    control_trans_start = 1'b0;
    r1 = avm_m1_read;
    a1 = avm_m1_address;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (control_trans_work === 1'b0) begin
        ok = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_counts();
    read_count = 0;
    ts_count = 0;
    rdv_count = 0;
    reads_while_busy = 0;
    first_lat = -1;
    work_hi_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    control_trans_start = 1'b0;
    control_trans_start_addr = '0;
    control_trans_stop_addr = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({avm_m1_read, avm_m1_write, trans_start, control_trans_work} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000",
               {avm_m1_read, avm_m1_write, trans_start, control_trans_work});
    else n_pass++;
    n_checks++;
    if (avm_m1_address !== 16'h0000)
      $display("FAIL reset_addr: got %h expected 0000", avm_m1_address);
    else n_pass++;
    n_checks++;
    if (avm_m1_writedata !== 32'h0)
      $display("FAIL reset_wdata: got %h expected 0", avm_m1_writedata);
    else n_pass++;
    n_checks++;
    if (trans_char !== 8'h00)
      $display("FAIL reset_char: got %h expected 00", trans_char);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic r1;
    logic [15:0] a1;
    bit ok;
    mem[16'h0010] = 8'h41;
    mem[16'h0011] = 8'h42;
    mem[16'h0012] = 8'h43;
    fin_delay = 20;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      exp_addrs.push_back(16'h0010 + 16'(i));
      exp_chars.push_back(8'h41 + 8'(i));
    end
    pulse_start(16'h0010, 16'h0013, r1, a1);
    n_checks++;
    if (r1 !== 1'b1 || a1 !== 16'h0010)
      $display("FAIL basic_first_read: got read=%b addr=%h expected read=1 addr=0010", r1, a1);
    else n_pass++;
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_idle: work still %b expected 0", control_trans_work);
    else n_pass++;
    n_checks++;
    if (first_lat !== 1) $display("FAIL basic_rdv_latency: got %0d expected 1", first_lat);
    else n_pass++;
    n_checks++;
    if (reads_while_busy !== 2)
      $display("FAIL basic_prefetch: got %0d reads during transmit expected 2", reads_while_busy);
    else n_pass++;
    // Finish seen in cycle M, send FSM idle in M+1, work low from M+2.
    n_checks++;
    if (work_fall_cyc !== fin_cyc + 2)
      $display("FAIL basic_work_fall: got cycle %0d expected %0d", work_fall_cyc, fin_cyc + 2);
    else n_pass++;
    n_checks++;
    if (trans_char !== 8'h43) $display("FAIL basic_char_hold: got %h expected 43", trans_char);
    else n_pass++;
    n_checks++;
    if (exp_addrs.size() != 0 || exp_chars.size() != 0)
      $display("FAIL basic_leftover: got %0d addrs %0d chars expected 0 0",
               exp_addrs.size(), exp_chars.size());
    else n_pass++;
  endtask

  task automatic test_empty_range();
    logic r1;
    logic [15:0] a1;
    bit ok;
    clear_counts();
    pulse_start(16'h0040, 16'h0040, r1, a1);
    n_checks++;
    if (r1 !== 1'b0) $display("FAIL empty_read: got %b expected 0", r1);
    else n_pass++;
    wait_idle(20, ok);
    repeat (5) @(negedge clk);
    n_checks++;
    if (work_hi_cnt !== 1) $display("FAIL empty_work_len: got %0d expected 1", work_hi_cnt);
    else n_pass++;
    n_checks++;
    if (read_count !== 0 || ts_count !== 0)
      $display("FAIL empty_activity: got reads=%0d starts=%0d expected 0 0", read_count, ts_count);
    else n_pass++;
  endtask

  task automatic test_waitrequest();
    logic r1;
    logic [15:0] a1;
    int stall_cycles;
    int stall_bad;
    bit done;
    mem[16'h0020] = 8'h5A;
    fin_delay = 8;
    clear_counts();
    exp_addrs.push_back(16'h0020);
    exp_chars.push_back(8'h5A);
    stall_left = 5;
    stall_cycles = 0;
    stall_bad = 0;
    done = 0;
    pulse_start(16'h0020, 16'h0021, r1, a1);
    for (int i = 0; i < 100; i++) begin
      if (i > 0) @(negedge clk);
      if (avm_m1_waitrequest) begin
        stall_cycles++;
        if (!(avm_m1_read === 1'b1 && avm_m1_address === 16'h0020)) stall_bad++;
      end
      if (control_trans_work === 1'b0) begin
        done = 1;
        break;
      end
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (!done) $display("FAIL stall_idle: work still %b expected 0", control_trans_work);
    else n_pass++;
    n_checks++;
    if (stall_cycles !== 5 || stall_bad !== 0)
      $display("FAIL stall_stable: got %0d stall cycles %0d unstable expected 5 0",
               stall_cycles, stall_bad);
    else n_pass++;
    n_checks++;
    if (read_count !== 1 || ts_count !== 1)
      $display("FAIL stall_counts: got reads=%0d starts=%0d expected 1 1", read_count, ts_count);
    else n_pass++;
  endtask

  task automatic test_restart_ignored();
    logic r1;
    logic [15:0] a1;
    bit ok;
    bit seen;
    fin_delay = 10;
    clear_counts();
    for (int i = 0; i < 4; i++) begin
      mem[16'h0050 + 16'(i)] = 8'h60 + 8'(i);
      mem[16'h0100 + 16'(i)] = 8'hE0 + 8'(i);
      exp_addrs.push_back(16'h0050 + 16'(i));
      exp_chars.push_back(8'h60 + 8'(i));
    end
    pulse_start(16'h0050, 16'h0054, r1, a1);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ts_count >= 1) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) $display("FAIL restart_first_char: got %0d starts expected 1", ts_count);
    else n_pass++;
    control_trans_start      = 1'b1;
    control_trans_start_addr = 16'h0100;
    control_trans_stop_addr  = 16'h0108;
    @(negedge clk);
    control_trans_start = 1'b0;
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL restart_idle: work still %b expected 0", control_trans_work);
    else n_pass++;
    n_checks++;
    if (read_count !== 4 || ts_count !== 4)
      $display("FAIL restart_counts: got reads=%0d starts=%0d expected 4 4", read_count, ts_count);
    else n_pass++;
    n_checks++;
    if (exp_addrs.size() != 0 || exp_chars.size() != 0)
      $display("FAIL restart_leftover: got %0d addrs %0d chars expected 0 0",
               exp_addrs.size(), exp_chars.size());
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic r1;
    logic [15:0] a1;
    bit ok;
    logic [15:0] addrs [3];
    addrs[0] = 16'hFFFE;
    addrs[1] = 16'hFFFF;
    addrs[2] = 16'h0000;
    fin_delay = 6;
    clear_counts();
    for (int i = 0; i < 3; i++) begin
      mem[addrs[i]] = 8'h61 + 8'(i);
      exp_addrs.push_back(addrs[i]);
      exp_chars.push_back(8'h61 + 8'(i));
    end
    pulse_start(16'hFFFE, 16'h0001, r1, a1);
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL wrap_idle: work still %b expected 0", control_trans_work);
    else n_pass++;
    n_checks++;
    if (ts_count !== 3 || read_count !== 3)
      $display("FAIL wrap_counts: got reads=%0d starts=%0d expected 3 3", read_count, ts_count);
    else n_pass++;
    n_checks++;
    if (exp_addrs.size() != 0 || exp_chars.size() != 0)
      $display("FAIL wrap_leftover: got %0d addrs %0d chars expected 0 0",
               exp_addrs.size(), exp_chars.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic r1;
    logic [15:0] a1;
    bit found;
    mem[16'h0030] = 8'h71;
    mem[16'h0031] = 8'h72;
    fin_delay = 60;
    clear_counts();
    exp_addrs.push_back(16'h0030);
    exp_addrs.push_back(16'h0031);
    exp_chars.push_back(8'h71);
    pulse_start(16'h0030, 16'h0032, r1, a1);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      if (i > 0) @(negedge clk);
      if (avm_m1_read && !avm_m1_waitrequest && avm_m1_address == 16'h0031) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) $display("FAIL rstmid_prefetch: no read at 0031 seen");
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({avm_m1_read, trans_start, control_trans_work} !== 3'b000)
      $display("FAIL rstmid_outputs: got read,start,work=%b expected 000",
               {avm_m1_read, trans_start, control_trans_work});
    else n_pass++;
    n_checks++;
    if (trans_char !== 8'h00) $display("FAIL rstmid_char: got %h expected 00", trans_char);
    else n_pass++;
    rst = 1'b0;
    repeat (80) @(negedge clk);
    n_checks++;
    if (rdv_count !== 2) $display("FAIL rstmid_late_rdv: got %0d data beats expected 2", rdv_count);
    else n_pass++;
    n_checks++;
    if (ts_count !== 1 || read_count !== 2 || control_trans_work !== 1'b0)
      $display("FAIL rstmid_quiet: got starts=%0d reads=%0d work=%b expected 1 2 0",
               ts_count, read_count, control_trans_work);
    else n_pass++;
    n_checks++;
    if (exp_addrs.size() != 0 || exp_chars.size() != 0)
      $display("FAIL rstmid_leftover: got %0d addrs %0d chars expected 0 0",
               exp_addrs.size(), exp_chars.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty_range();
    test_waitrequest();
    test_restart_ignored();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
